// File: rtl/cam_if.sv
// Camera-side byte bus (OV7670-style).
//   cam_pclk  : pixel-byte clock
//   cam_vsync : frame sync, active high
//   cam_href  : active byte qualifier
//   cam_data  : byte data, RGB565 high byte first
// master drives the bus (pattern source), slave receives it (capture front-end).
interface cam_if;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (output cam_pclk, cam_vsync, cam_href, cam_data);
    modport slave  (input  cam_pclk, cam_vsync, cam_href, cam_data);
endinterface

// File: rtl/cam_pattern_gen.sv
// Camera stimulus source: produces an OV7670-style RGB565 byte stream with
// configurable geometry, blanking and test pattern.
//   r_clk50m    : 50 MHz clock; cam_pclk runs at half this rate
//   reset_n     : asynchronous active-low reset
//   enable      : run request; checked in IDLE and at the end of each frame
//   mode        : 0 fixed, 1 colour bars, 2 ramp, 3 checker (latched per frame)
//   fixed_color : RGB565 value for mode 0 (latched per frame)
//   cam         : camera bus (master side)
//   frame_start : one-cycle pulse as each frame begins
//   frame_cnt   : number of frames started, wraps
module cam_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 288,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        r_clk50m,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] fixed_color,
    cam_if.master       cam,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int L    = 2 * H_ACTIVE + H_BLANK;
    localparam int SW   = $clog2(L);
    localparam int LMX0 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int LMX1 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LMAX = (LMX0 > LMX1) ? LMX0 : LMX1;
    localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;
    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [SW-1:0] SLOT_LAST = SW'(L - 1);
    localparam logic [SW-1:0] HREF_END  = SW'(2 * H_ACTIVE);
    // Zero-length phases are skipped, so their "last line" value is never used.
    localparam logic [LW-1:0] VS_LAST = LW'(V_SYNC - 1);
    localparam logic [LW-1:0] VB_LAST = LW'(((V_BACK > 0) ? V_BACK : 1) - 1);
    localparam logic [LW-1:0] VA_LAST = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST = LW'(((V_FRONT > 0) ? V_FRONT : 1) - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t          state, state_nxt, after_front;
    logic            pclk_q;
    logic [SW-1:0]   slot_q;
    logic [LW-1:0]   line_q;
    logic [1:0]      mode_q;
    logic [15:0]     color_q;
    logic            line_end;
    logic            new_frame;

    // A line ends on the pclk 1->0 cycle of the last slot.
    assign line_end  = pclk_q && (slot_q == SLOT_LAST);
    assign new_frame = (state_nxt == VSYNC) && (state != VSYNC);

    // ---------------- state register ----------------
    always_ff @(posedge r_clk50m or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---------------- next-state ----------------
    always_comb begin
        state_nxt   = state;
        after_front = enable ? VSYNC : IDLE;
        case (state)
            IDLE:   if (enable) state_nxt = VSYNC;
            VSYNC:  if (line_end && line_q == VS_LAST)
                        state_nxt = (V_BACK > 0) ? VBACK : ACTIVE;
            VBACK:  if (line_end && line_q == VB_LAST) state_nxt = ACTIVE;
            ACTIVE: if (line_end && line_q == VA_LAST)
                        state_nxt = (V_FRONT > 0) ? VFRONT : after_front;
            VFRONT: if (line_end && line_q == VF_LAST) state_nxt = after_front;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- counters, pclk, frame bookkeeping ----------------
    always_ff @(posedge r_clk50m or negedge reset_n) begin
        if (!reset_n) begin
            pclk_q      <= 1'b0;
            slot_q      <= '0;
            line_q      <= '0;
            mode_q      <= 2'd0;
            color_q     <= 16'h0000;
            frame_start <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            frame_start <= new_frame;
            if (new_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
                mode_q    <= mode;
                color_q   <= fixed_color;
            end
            if (state == IDLE || state_nxt == IDLE) begin
                // Leaving IDLE starts the frame in the pclk-low half of slot 0.
                pclk_q <= 1'b0;
                slot_q <= '0;
                line_q <= '0;
            end else begin
                pclk_q <= ~pclk_q;
                if (pclk_q) begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q <= '0;
                        line_q <= (state_nxt != state) ? '0 : line_q + LW'(1);
                    end else begin
                        slot_q <= slot_q + SW'(1);
                    end
                end
            end
        end
    end

    // ---------------- outputs ----------------
    // Everything below decodes registers that only change on the pclk
    // falling cycle, so bus values are stable across the rising pclk edge.
    logic [15:0] px;
    logic [2:0]  bar;
    logic        chk;
    logic [15:0] pix;
    logic        href;
    logic [7:0]  data;

    always_comb begin
        px   = 16'(slot_q >> 1);
        bar  = 3'(px / 16'(BAR_W));
        chk  = 1'(((16'(slot_q) >> 4) ^ (16'(line_q) >> 3)) & 16'h0001);
        case (mode_q)
            2'd0: pix = color_q;
            2'd1: begin
                case (bar)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd2:    pix = {px[4:0], px[5:0], px[4:0]};
            default: pix = chk ? 16'hFFFF : 16'h0000;
        endcase
        href = (state == ACTIVE) && (slot_q < HREF_END);
        data = 8'h00;
        if (href) data = slot_q[0] ? pix[7:0] : pix[15:8];
    end

    assign cam.cam_pclk  = pclk_q;
    assign cam.cam_vsync = (state == VSYNC);
    assign cam.cam_href  = href;
    assign cam.cam_data  = data;

endmodule

// File: tb/tb_cam_pattern_gen.sv
module tb_cam_pattern_gen;

    localparam int HA = 8, VA = 4, HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int LCLK = 2 * (2 * HA + HB);        // clocks per line
    localparam int FCLK = LCLK * (VS + VB + VA + VF); // clocks per frame
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        r_clk50m = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fixed_color = 16'h0000;
    logic        frame_start;
    logic [15:0] frame_cnt;

    cam_if cam ();

    cam_pattern_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .r_clk50m    (r_clk50m),
        .reset_n     (reset_n),
        .enable      (enable),
        .mode        (mode),
        .fixed_color (fixed_color),
        .cam         (cam),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #10 r_clk50m = ~r_clk50m;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [1:0]  cur_m = 2'd0;
    logic [15:0] cur_c = 16'h0000;

    // Reference pixel straight from the pattern definitions.
    function automatic logic [15:0] ref_pixel(input logic [1:0] m, input logic [15:0] c,
                                              input int x, input int y);
        case (m)
            2'd0:    return c;
            2'd1:    return BARS[x / (HA / 8)];
            2'd2:    return 16'(((x % 32) << 11) | ((x % 64) << 5) | (x % 32));
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Expected {frame_start, pclk, vsync, href, data} k clocks after frame_start.
    function automatic logic [11:0] ref_out(input int k, input logic [1:0] m, input logic [15:0] c);
        int line, slot;
        logic act, hr, fs, pc, vs;
        logic [15:0] pix;
        logic [7:0] d;
        line = k / LCLK;
        slot = (k % LCLK) / 2;
        fs   = (k == 0);
        pc   = (k % 2) == 1;
        vs   = line < VS;
        act  = (line >= VS + VB) && (line < VS + VB + VA);
        hr   = act && (slot < 2 * HA);
        d    = 8'h00;
        if (hr) begin
            pix = ref_pixel(m, c, slot / 2, line - (VS + VB));
            d   = (slot % 2 == 1) ? pix[7:0] : pix[15:8];
        end
        return {fs, pc, vs, hr, d};
    endfunction

    function automatic logic [11:0] dut_out();
        return {frame_start, cam.cam_pclk, cam.cam_vsync, cam.cam_href, cam.cam_data};
    endfunction

    task automatic wait_start(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge r_clk50m);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s frame_start not seen within %0d cycles", name, budget);
        end
    endtask

    // Called at the negedge where frame_start is high (k=0). Checks the whole
    // frame against the model for (cur_m, cur_c); at clock poke_k it changes the
    // inputs to (nm, nc, nen), which must only take effect at the next frame.
    task automatic run_frame(input string name, input int poke_k,
                             input logic [1:0] nm, input logic [15:0] nc, input logic nen);
        logic [11:0] got, want;
        int vs_cnt, first_href, href_cnt, href_rise;
        logic prev_href;
        vs_cnt = 0; first_href = -1; href_cnt = 0; href_rise = 0; prev_href = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++;
        if (frame_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s frame_cnt got=%0d want=%0d", name, frame_cnt, exp_cnt);
        end
        for (int k = 0; k < FCLK; k++) begin
            if (k == poke_k) begin
                mode = nm; fixed_color = nc; enable = nen;
            end
            got  = dut_out();
            want = ref_out(k, cur_m, cur_c);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s k=%0d {fs,pclk,vs,href,data} got=%h want=%h", name, k, got, want);
            end
            if (cam.cam_vsync === 1'b1) vs_cnt++;
            if (cam.cam_href === 1'b1) begin
                href_cnt++;
                if (first_href < 0) first_href = k;
                if (!prev_href) href_rise++;
            end
            prev_href = (cam.cam_href === 1'b1);
            @(negedge r_clk50m);
        end
        n_cmp++;
        if (vs_cnt != LCLK * VS) begin
            n_bad++; $display("FAIL %s vsync_len got=%0d want=%0d", name, vs_cnt, LCLK * VS);
        end
        n_cmp++;
        if (first_href != LCLK * (VS + VB)) begin
            n_bad++; $display("FAIL %s href_first got=%0d want=%0d", name, first_href, LCLK * (VS + VB));
        end
        n_cmp++;
        if (href_cnt != 4 * HA * VA || href_rise != VA) begin
            n_bad++;
            $display("FAIL %s href_cycles/lines got=%0d/%0d want=%0d/%0d",
                     name, href_cnt, href_rise, 4 * HA * VA, VA);
        end
        n_cmp++;
        if (frame_start !== nen) begin
            n_bad++; $display("FAIL %s next_frame_start got=%b want=%b", name, frame_start, nen);
        end
        cur_m = nm;
        cur_c = nc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge r_clk50m);
        n_cmp++;
        if (dut_out() !== 12'h000 || frame_cnt !== 16'h0000) begin
            n_bad++; $display("FAIL reset_state got=%h/%h want=000/0000", dut_out(), frame_cnt);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge r_clk50m);
            n_cmp++;
            if (dut_out() !== 12'h000 || frame_cnt !== 16'h0000) begin
                n_bad++; $display("FAIL idle_quiet cyc=%0d got=%h/%h want=000/0000", i, dut_out(), frame_cnt);
            end
        end
    endtask

    task automatic test_frame_timing();
        mode = 2'd0; fixed_color = 16'hA55A; enable = 1'b1;
        cur_m = 2'd0; cur_c = 16'hA55A;
        @(negedge r_clk50m);
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL start_latency frame_start got=%b want=1", frame_start);
        end
        wait_start(4, "timing_start");
        run_frame("timing1", 30, 2'd0, 16'hA55A, 1'b1);
        run_frame("timing2", 100, 2'd1, 16'h1234, 1'b1);
    endtask

    task automatic test_color_bars();
        run_frame("bars", 150, 2'd0, 16'(($urandom)), 1'b1);
    endtask

    task automatic test_mode_latch();
        // Mode and colour change during a fixed-colour frame; the frame must not notice.
        run_frame("latch_fixed", 120, 2'd3, 16'(($urandom)), 1'b1);
        run_frame("latch_checker", 10, 2'd2, 16'h0000, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            run_frame("random", $urandom_range(1, FCLK - 2), 2'($urandom_range(0, 3)),
                      16'($urandom), 1'b1);
        end
    endtask

    task automatic test_enable_drop();
        run_frame("drop", $urandom_range(LCLK * (VS + VB), LCLK * (VS + VB + VA) - 1),
                  cur_m, cur_c, 1'b0);
        for (int i = 0; i < 60; i++) begin
            n_cmp++;
            if (dut_out() !== 12'h000 || frame_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL drop_idle cyc=%0d got=%h/%0d want=000/%0d", i, dut_out(), frame_cnt, exp_cnt);
            end
            @(negedge r_clk50m);
        end
    endtask

    task automatic test_mid_reset();
        mode = 2'd0; fixed_color = 16'hC3C3; enable = 1'b1;
        cur_m = 2'd0; cur_c = 16'hC3C3;
        @(negedge r_clk50m);
        wait_start(4, "mreset_start");
        repeat (90) @(negedge r_clk50m);
        n_cmp++;
        if (cam.cam_href !== 1'b1) begin
            n_bad++; $display("FAIL mreset_href got=%b want=1", cam.cam_href);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out() !== 12'h000 || frame_cnt !== 16'h0000) begin
            n_bad++; $display("FAIL mreset_async got=%h/%h want=000/0000", dut_out(), frame_cnt);
        end
        @(negedge r_clk50m);
        reset_n = 1'b1;
        exp_cnt = 16'h0000;
        @(negedge r_clk50m);
        wait_start(4, "mreset_restart");
        run_frame("mreset_frame", 50, 2'd0, 16'hC3C3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_color_bars();
        test_mode_latch();
        test_random();
        test_enable_drop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
